// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one iteration per clock, with sign fixup and a registered result.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_pipe,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_pipe,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int IW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                sa, sb;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       rem_sh, trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, sel;

    // Sign flags of the incoming op: only signed operand positions count.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sa = op_a[XLEN-1];
                sb = op_b[XLEN-1];
            end
            3'b010: sa = op_a[XLEN-1];
            default: ;
        endcase
        a_mag = sa ? -op_a : op_a;
        b_mag = sb ? -op_b : op_b;
    end

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, b_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
        rem_fix  = neg_a_q ? -rem_q : rem_q;
        unique case (f3_q)
            3'b000:                 sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel = quo_fix;
            default:                sel = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        res_d      = res_q;
        stall_pipe = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_pipe = start;
                if (start && !flush_pipe) begin
                    f3_d    = funct3;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    neg_a_d = sa;
                    neg_b_d = sb;
                    cnt_d   = '0;
                    prod_d  = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    if (funct3[2] && op_b == '0) begin
                        res_d   = funct3[1] ? op_a : '1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_pipe = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (f3_q[2]) begin
                    rem_d = trial[XLEN] ? rem_sh[XLEN-1:0]
                                        : trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                end else if (b_q[cnt_q[IW-1:0]]) begin
                    prod_d = prod_q
                           + ({{XLEN{1'b0}}, a_q} << cnt_q);
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                stall_pipe = 1'b1;
                if (!flush_pipe) begin
                    res_d = sel;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush_pipe) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result       = res_q;
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs an
// arithmetic reference, and flush / back-to-back / reset sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_pipe;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_pipe;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp = '0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_pipe   (flush_pipe),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .stall_pipe   (stall_pipe),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h req=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ref_model = '0;
        case (f3)
            3'd0: begin up = ua * ub; ref_model = up[31:0]; end
            3'd1: begin p = sa * sb; ref_model = p[63:32]; end
            3'd2: begin p = sa * ub; ref_model = p[63:32]; end
            3'd3: begin up = ua * ub; ref_model = up[63:32]; end
            3'd4: begin
                if (b == 0) ref_model = 32'hFFFFFFFF;
                else begin p = sa / sb; ref_model = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) ref_model = 32'hFFFFFFFF;
                else begin p = ua / ub; ref_model = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) ref_model = a;
                else begin p = sa % sb; ref_model = p[31:0]; end
            end
            default: begin
                if (b == 0) ref_model = a;
                else begin p = ua % ub; ref_model = p[31:0]; end
            end
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int  exp_lat;
        int  lat;
        bit  seen;
        bit  hs_err;
        logic [31:0] res;
        exp_lat = (f3[2] && b == 0) ? 1 : 34;
        seen    = 0;
        hs_err  = 0;
        lat     = -1;
        res     = '0;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        for (int c = 0; c <= 40 && !seen; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            if (stall_pipe !== (c < exp_lat)) hs_err = 1;
            if (busy !== (c >= 1 && c <= exp_lat)) hs_err = 1;
            if (result_valid === 1'b1) begin
                seen = 1;
                lat  = c;
                res  = result;
            end
        end
        start = 1'b0;
        chk({nm, "_handshake"}, 64'(hs_err), 64'd0);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_result"}, res, exp);
        last_exp = exp;
    endtask

    vec_t vecs[$];

    initial begin
        int v1, v2;
        logic [31:0] r1, r2;
        bit seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset      = 1'b1;
        flush_pipe = 1'b0;
        start      = 1'b0;
        funct3     = '0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall_pipe), 64'd0);
        chk("reset_valid", 64'(result_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14});
        vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2});
        vecs.push_back('{3'd5, 32'd123,      32'd0,        32'hFFFFFFFF});
        vecs.push_back('{3'd6, 32'd5,        32'd0,        32'd5});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a,
                   vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb,
                   ref_model(rf, ra, rb));
        end

        // Flush mid-multiply at cycle 10, then a fresh MUL at cycle 12.
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start      = 1'b0;
                flush_pipe = (c == 10);
            end
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1;
            if (c == 10) chk("flush_cyc_stall", 64'(stall_pipe), 64'd1);
            if (c == 11) begin
                chk("flush_busy", 64'(busy), 64'd0);
                chk("flush_stall", 64'(stall_pipe), 64'd0);
                chk("flush_hold", result, last_exp);
            end
        end
        flush_pipe = 1'b0;
        chk("flush_novalid", 64'(seen), 64'd0);
        run_op("after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

        // Flush beats start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; flush_pipe = 1'b1; funct3 = 3'd1;
        @(posedge clk); #1;
        start = 1'b0; flush_pipe = 1'b0;
        @(negedge clk);
        chk("flush_vs_start", 64'(busy), 64'd0);

        // start held across DONE; operand changes mid-op are ignored.
        v1 = -1; v2 = -1; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        for (int c = 0; c <= 75; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 5) begin op_a = 32'd200; op_b = 32'd3; end
                if (c == 34) begin
                    funct3 = 3'd7; op_a = 32'd100; op_b = 32'd7;
                end
                if (c == 36) start = 1'b0;
            end
            @(negedge clk);
            if (result_valid === 1'b1) begin
                if (v1 < 0) begin v1 = c; r1 = result; end
                else if (v2 < 0) begin v2 = c; r2 = result; end
            end
            if (c == 34) chk("b2b_done_stall", 64'(stall_pipe), 64'd0);
            if (c == 35) begin
                chk("b2b_idle_busy", 64'(busy), 64'd0);
                chk("b2b_idle_stall", 64'(stall_pipe), 64'd1);
            end
            if (c == 36) chk("b2b_accept", 64'(busy), 64'd1);
        end
        start = 1'b0;
        chk("b2b_lat1", 64'(v1), 64'd34);
        chk("b2b_res1", r1, 64'd14);
        chk("b2b_lat2", 64'(v2), 64'd69);
        chk("b2b_res2", r2, 64'd2);

        // Reset at cycle 20 of a multiply.
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                reset = (c == 20);
            end
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1;
            if (c == 21) begin
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_stall", 64'(stall_pipe), 64'd0);
                chk("rst_valid", 64'(result_valid), 64'd0);
                chk("rst_result", result, 64'd0);
            end
        end
        reset = 1'b0;
        chk("rst_novalid", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
